// File: rtl/alu_pkg.sv
// Shared definitions for the Simple ALU blocks.
//   state_t : FSM encoding for the bit-serial add/sub engine
//   OP_ADD / OP_SUB : operation select codes
package alu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_add_sub_if.sv
// Request/result bundle for serial_add_sub.
//   start, op, a, b : request side (driven by the master)
//   busy, done, result, carry_out, overflow, zero : status/result (driven by the engine)
//   state : FSM state, exported for observation
// Handshake: a request is taken on a rising edge where start=1 and busy=0.
// start is ignored while busy=1 and nothing is queued. done is a one-cycle
// pulse marking result and flags valid; they then hold until the next
// accepted start.
interface serial_add_sub_if #(parameter int WIDTH = 8);
  import alu_pkg::*;

  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             zero;
  state_t           state;

  modport master (
    output start, op, a, b,
    input  busy, done, result, carry_out, overflow, zero, state
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, carry_out, overflow, zero, state
  );

endinterface

// File: rtl/full_adder.sv
// One-bit full-adder cell.
//   num_1, num_2 : operand bits
//   c            : carry in
//   sum, carry   : sum bit and carry out
module Full_Adder (
  input  logic num_1,
  input  logic num_2,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = num_1 ^ num_2 ^ c;
  assign carry = (num_1 & num_2) | (c & (num_1 ^ num_2));

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor. Latches two WIDTH-bit operands on an accepted
// start and pushes one bit pair plus the registered carry through a single
// full-adder cell per clock, LSB first. done pulses WIDTH+1 cycles after the
// accepting edge with result, carry_out, overflow and zero.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : serial_add_sub_if slave (request, status, result, FSM state)
module serial_add_sub
  import alu_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  serial_add_sub_if.slave bus
);

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_sh, b_sh, result_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_out_q, overflow_q, zero_q;
  logic             fa_sum, fa_carry;
  logic             accept, last_bit;
  logic [WIDTH-1:0] result_next;

  assign accept      = (state_q == ST_IDLE) && bus.start;
  assign last_bit    = (cnt_q == CNT_W'(WIDTH - 1));
  assign result_next = {fa_sum, result_q[WIDTH-1:1]};

  Full_Adder u_cell (
    .num_1 (a_sh[0]),
    .num_2 (b_sh[0]),
    .c     (carry_q),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_RUN;
      ST_RUN:  if (last_bit)  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: operand shifters, carry, bit counter, result and flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh        <= '0;
      b_sh        <= '0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
    end else if (accept) begin
      a_sh        <= bus.a;
      // Subtract is a + ~b + 1: invert b here and seed the carry with op.
      b_sh        <= (bus.op == OP_SUB) ? ~bus.b : bus.b;
      carry_q     <= bus.op;
      cnt_q       <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
    end else if (state_q == ST_RUN) begin
      result_q <= result_next;
      a_sh     <= a_sh >> 1;
      b_sh     <= b_sh >> 1;
      carry_q  <= fa_carry;
      cnt_q    <= cnt_q + CNT_W'(1);
      if (last_bit) begin
        // During the MSB step carry_q is the carry into the MSB, so signed
        // overflow is that carry XOR the carry out of the MSB.
        carry_out_q <= fa_carry;
        overflow_q  <= carry_q ^ fa_carry;
        zero_q      <= (result_next == '0);
      end
    end
  end

  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.result    = result_q;
  assign bus.carry_out = carry_out_q;
  assign bus.overflow  = overflow_q;
  assign bus.zero      = zero_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Testbench for serial_add_sub: directed cases with literal expectations plus
// randomized traffic checked every cycle against an arithmetic reference model.
module tb_serial_add_sub;
  import alu_pkg::*;

  localparam int W  = 8;
  localparam int EW = W + 3;  // {result, carry_out, overflow, zero}

  logic clk;
  logic rst_n;

  serial_add_sub_if #(.WIDTH(W)) bus ();

  serial_add_sub #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [EW-1:0] model_calc(input logic [W-1:0] x, input logic [W-1:0] y,
                                               input logic o);
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         c, v;
    if (o == OP_ADD) begin
      s = {1'b0, x} + {1'b0, y};
      c = s[W];
    end else begin
      s = {1'b0, x} - {1'b0, y};
      c = (x >= y);  // no borrow
    end
    r = s[W-1:0];
    if (o == OP_ADD) v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    else             v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    return {r, c, v, (r == '0)};
  endfunction

  // m_left: cycles remaining in the current operation (0 = idle).
  // An accepted start gives WIDTH+1 busy cycles, the last one being done.
  logic [EW-1:0] exp_q[$];
  int            m_left = 0;
  logic [EW-1:0] m_pending = '0;
  logic [EW-1:0] hold = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0;
      hold   = '0;
      exp_q.delete();
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 1) hold = m_pending;
    end else if (bus.start) begin
      m_left    = W + 1;
      m_pending = model_calc(bus.a, bus.b, bus.op);
      exp_q.push_back(m_pending);
      hold = '0;
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [EW-1:0] dut_out;
  assign dut_out = {bus.result, bus.carry_out, bus.overflow, bus.zero};

  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (!rst_n) begin
      chk("rst_outputs", {bus.busy, bus.done, dut_out}, '0);
    end else begin
      chk("busy", 32'(bus.busy), 32'(m_left > 0));
      chk("done", 32'(bus.done), 32'(m_left == 1));
      if (m_left == 1) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_empty", 32'(1), 32'(0));
        end else begin
          e = exp_q.pop_front();
          chk("done_result", 32'(dut_out), 32'(e));
        end
      end else if (m_left == 0) begin
        chk("held_result", 32'(dut_out), 32'(hold));
      end else begin
        chk("run_no_x", 32'($isunknown(dut_out)), 32'(0));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 4 * W) begin
      cyc();
      n++;
    end
    chk("wait_idle", 32'(bus.busy), 32'(0));
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic top,
                        input logic [W-1:0] er, input logic ec, input logic ev, input logic ez,
                        input string name);
    int k = 0;
    bus.a = ta; bus.b = tb_v; bus.op = top; bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    while (!bus.done && k < 3 * W) begin
      cyc();
      k++;
    end
    chk({name, "_latency"}, 32'(k), 32'(W));
    chk({name, "_result"}, 32'(bus.result), 32'(er));
    chk({name, "_carry"}, 32'(bus.carry_out), 32'(ec));
    chk({name, "_ovf"}, 32'(bus.overflow), 32'(ev));
    chk({name, "_zero"}, 32'(bus.zero), 32'(ez));
    cyc();
    chk({name, "_busy_after"}, 32'(bus.busy), 32'(0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int k;
    int done_at[$];
    int t;

    rst_n = 1'b0;
    bus.start = 1'b0; bus.op = OP_ADD; bus.a = '0; bus.b = '0;

    // Pin the model with hand-computed values.
    chk("model_add", 32'(model_calc(8'h0F, 8'h01, OP_ADD)), 32'({8'h10, 3'b000}));
    chk("model_wrap", 32'(model_calc(8'hFF, 8'h01, OP_ADD)), 32'({8'h00, 3'b101}));
    chk("model_ovf", 32'(model_calc(8'h7F, 8'h01, OP_ADD)), 32'({8'h80, 3'b010}));
    chk("model_sub", 32'(model_calc(8'h05, 8'h07, OP_SUB)), 32'({8'hFE, 3'b000}));
    chk("model_subov", 32'(model_calc(8'h80, 8'h01, OP_SUB)), 32'({8'h7F, 3'b110}));

    cyc(); cyc();
    chk("reset_state", 32'({bus.busy, bus.done, dut_out}), 32'(0));
    chk("reset_fsm", 32'(bus.state), 32'(ST_IDLE));
    rst_n = 1'b1;
    cyc();

    // Directed arithmetic
    run_op(8'h0F, 8'h01, OP_ADD, 8'h10, 1'b0, 1'b0, 1'b0, "add");
    run_op(8'hFF, 8'h01, OP_ADD, 8'h00, 1'b1, 1'b0, 1'b1, "add_wrap");
    run_op(8'h7F, 8'h01, OP_ADD, 8'h80, 1'b0, 1'b1, 1'b0, "add_ovf");
    run_op(8'h05, 8'h07, OP_SUB, 8'hFE, 1'b0, 1'b0, 1'b0, "sub_borrow");
    run_op(8'h80, 8'h01, OP_SUB, 8'h7F, 1'b1, 1'b1, 1'b0, "sub_ovf");

    // Start ignored while busy (RUN and DONE)
    bus.a = 8'h01; bus.b = 8'h01; bus.op = OP_ADD; bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    cyc(); cyc();
    bus.a = 8'hAA; bus.b = 8'h55; bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    k = 0;
    while (!bus.done && k < 3 * W) begin
      cyc();
      k++;
    end
    chk("ign_result", 32'(bus.result), 32'(8'h02));
    chk("ign_done", 32'(bus.done), 32'(1));
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    chk("ign_busy_after", 32'(bus.busy), 32'(0));
    chk("ign_held", 32'(bus.result), 32'(8'h02));
    cyc();
    chk("ign_still_idle", 32'(bus.busy), 32'(0));

    // Asynchronous reset mid-operation
    bus.a = 8'h11; bus.b = 8'h22; bus.op = OP_ADD; bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    cyc(); cyc(); cyc();
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", 32'({bus.busy, bus.done, dut_out}), 32'(0));
    chk("abort_fsm", 32'(bus.state), 32'(ST_IDLE));
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    run_op(8'h03, 8'h04, OP_ADD, 8'h07, 1'b0, 1'b0, 1'b0, "after_reset");

    // Back-to-back with start held high
    bus.a = 8'h3C; bus.b = 8'h5A; bus.op = OP_ADD; bus.start = 1'b1;
    for (int i = 0; i < 4 * (W + 2) + 2; i++) begin
      cyc();
      if (bus.done) begin
        done_at.push_back(i);
        chk("b2b_result", 32'(bus.result), 32'(8'h96));
      end
    end
    bus.start = 1'b0;
    chk("b2b_count_ge3", 32'(done_at.size() >= 3), 32'(1));
    for (int i = 1; i < done_at.size(); i++)
      chk("b2b_spacing", 32'(done_at[i] - done_at[i-1]), 32'(W + 2));
    wait_idle();

    // Randomized traffic, including start pulses and operand churn while busy
    for (int i = 0; i < 1500; i++) begin
      bus.start = ($urandom_range(0, 2) == 0);
      bus.op    = 1'($urandom_range(0, 1));
      bus.a     = W'($urandom_range(0, (1 << W) - 1));
      bus.b     = W'($urandom_range(0, (1 << W) - 1));
      if ($urandom_range(0, 9) == 0) begin
        t = $urandom_range(0, 3);
        bus.a = (t == 0) ? '0 : (t == 1) ? '1 : (t == 2) ? W'(1 << (W - 1)) : W'((1 << (W - 1)) - 1);
      end
      cyc();
    end
    bus.start = 1'b0;
    wait_idle();
    cyc(); cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
